// File: rtl/vend_pkg.sv
// Shared types and constants for the vending front end: coin denominations,
// their cent values and the credit accumulator states.
package vend_pkg;

   typedef enum logic [1:0] {
      COIN_5   = 2'd0,
      COIN_10  = 2'd1,
      COIN_25  = 2'd2,
      COIN_100 = 2'd3
   } coin_type_t;

   localparam int COIN_5_VAL   = 5;
   localparam int COIN_10_VAL  = 10;
   localparam int COIN_25_VAL  = 25;
   localparam int COIN_100_VAL = 100;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      HOLD   = 2'd2,
      REFUND = 2'd3
   } acc_state_t;

   localparam int MAX_CREDIT_DEF = 200;

endpackage

// File: rtl/coin_value_decode.sv
// Combinational coin denomination to cent value decoder.
module coin_value_decode
   import vend_pkg::*;
#(
   parameter int CW = 8
) (
   input  logic [1:0]    coin_type_i,
   output logic [CW-1:0] value_o
);

   coin_type_t ct;

   always_comb begin
      ct      = coin_type_t'(coin_type_i);
      value_o = '0;
      case (ct)
         COIN_5:   value_o = CW'(COIN_5_VAL);
         COIN_10:  value_o = CW'(COIN_10_VAL);
         COIN_25:  value_o = CW'(COIN_25_VAL);
         COIN_100: value_o = CW'(COIN_100_VAL);
         default:  value_o = '0;
      endcase
   end

endmodule

// File: rtl/coin_credit_acc.sv
// Coin credit accumulator: validates coins against a credit ceiling, signals
// when the drink price is covered and presents change/refund until acknowledged.
module coin_credit_acc
   import vend_pkg::*;
#(
   parameter int CW         = 8,
   parameter int MAX_CREDIT = MAX_CREDIT_DEF
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          coin_valid,
   input  logic [1:0]    coin_type,
   input  logic [CW-1:0] price,
   input  logic          cancel,
   input  logic          vend_done,
   input  logic          refund_ack,
   output logic          coin,
   output logic          coin_reject,
   output logic [CW-1:0] credit,
   output logic          refund_valid,
   output logic [CW-1:0] refund_amt
);

   localparam logic [CW:0] MAX_SUM = (CW+1)'(MAX_CREDIT);

   acc_state_t    state_q;
   logic [CW-1:0] credit_q;
   logic [CW-1:0] price_q;
   logic          coin_q;
   logic          coin_reject_q;
   logic          refund_valid_q;
   logic [CW-1:0] refund_amt_q;

   logic [CW-1:0] coin_val_d;
   logic [CW:0]   sum_d;
   logic [CW-1:0] remainder_d;

   coin_value_decode #(.CW(CW)) u_decode (
      .coin_type_i (coin_type),
      .value_o     (coin_val_d)
   );

   // Sum carries one extra bit so an oversized coin can never wrap the credit.
   assign sum_d       = {1'b0, credit_q} + {1'b0, coin_val_d};
   assign remainder_d = credit_q - price_q;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q        <= IDLE;
         credit_q       <= '0;
         price_q        <= '0;
         coin_q         <= 1'b0;
         coin_reject_q  <= 1'b0;
         refund_valid_q <= 1'b0;
         refund_amt_q   <= '0;
      end else begin
         coin_q        <= 1'b0;
         coin_reject_q <= 1'b0;
         case (state_q)
            IDLE, ACCUM: begin
               if (cancel) begin
                  coin_reject_q <= coin_valid;
                  if (state_q == ACCUM) begin
                     state_q        <= REFUND;
                     refund_valid_q <= 1'b1;
                     refund_amt_q   <= credit_q;
                  end
               end else if (coin_valid) begin
                  if (sum_d <= MAX_SUM) begin
                     credit_q <= sum_d[CW-1:0];
                     if (sum_d >= {1'b0, price}) begin
                        state_q <= HOLD;
                        price_q <= price;
                        coin_q  <= 1'b1;
                     end else begin
                        state_q <= ACCUM;
                     end
                  end else begin
                     coin_reject_q <= 1'b1;
                  end
               end else if (state_q == ACCUM && credit_q >= price) begin
                  // Price was lowered beneath the credit already held.
                  state_q <= HOLD;
                  price_q <= price;
                  coin_q  <= 1'b1;
               end
            end
            HOLD: begin
               coin_reject_q <= coin_valid;
               if (vend_done) begin
                  if (remainder_d != '0) begin
                     state_q        <= REFUND;
                     credit_q       <= remainder_d;
                     refund_valid_q <= 1'b1;
                     refund_amt_q   <= remainder_d;
                  end else begin
                     state_q  <= IDLE;
                     credit_q <= '0;
                  end
               end else if (cancel) begin
                  state_q        <= REFUND;
                  refund_valid_q <= 1'b1;
                  refund_amt_q   <= credit_q;
               end
            end
            REFUND: begin
               coin_reject_q <= coin_valid;
               if (refund_ack) begin
                  state_q        <= IDLE;
                  credit_q       <= '0;
                  refund_valid_q <= 1'b0;
                  refund_amt_q   <= '0;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign coin         = coin_q;
   assign coin_reject  = coin_reject_q;
   assign credit       = credit_q;
   assign refund_valid = refund_valid_q;
   assign refund_amt   = refund_amt_q;

endmodule

// File: tb/tb_coin_credit_acc.sv
// Directed bench for coin_credit_acc with hand-computed expectations.
module tb_coin_credit_acc;

   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          resetn;
   logic          coin_valid;
   logic [1:0]    coin_type;
   logic [CW-1:0] price;
   logic          cancel;
   logic          vend_done;
   logic          refund_ack;
   logic          coin;
   logic          coin_reject;
   logic [CW-1:0] credit;
   logic          refund_valid;
   logic [CW-1:0] refund_amt;

   int checks   = 0;
   int failures = 0;

   coin_credit_acc #(.CW(CW), .MAX_CREDIT(200)) dut (
      .clk          (clk),
      .resetn       (resetn),
      .coin_valid   (coin_valid),
      .coin_type    (coin_type),
      .price        (price),
      .cancel       (cancel),
      .vend_done    (vend_done),
      .refund_ack   (refund_ack),
      .coin         (coin),
      .coin_reject  (coin_reject),
      .credit       (credit),
      .refund_valid (refund_valid),
      .refund_amt   (refund_amt)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic drop_coin(input logic [1:0] t);
      coin_valid = 1'b1;
      coin_type  = t;
      cyc();
      coin_valid = 1'b0;
   endtask

   task automatic ack_refund();
      refund_ack = 1'b1;
      cyc();
      refund_ack = 1'b0;
   endtask

   initial begin
      resetn = 1'b0; coin_valid = 1'b0; coin_type = 2'd0; price = 8'd35;
      cancel = 1'b0; vend_done = 1'b0; refund_ack = 1'b0;
      cyc(); cyc();
      resetn = 1'b1;
      chk("rst_credit", credit, 0);
      chk("rst_coin", coin, 0);
      chk("rst_reject", coin_reject, 0);
      chk("rst_rvalid", refund_valid, 0);
      chk("rst_ramt", refund_amt, 0);

      // Exact payment
      price = 8'd35;
      drop_coin(2'd2);
      chk("exact_credit25", credit, 25);
      chk("exact_nocoin", coin, 0);
      drop_coin(2'd1);
      chk("exact_credit35", credit, 35);
      chk("exact_coin", coin, 1);
      cyc();
      chk("exact_coin_once", coin, 0);
      vend_done = 1'b1; cyc(); vend_done = 1'b0;
      chk("exact_vend_credit", credit, 0);
      chk("exact_vend_norefund", refund_valid, 0);

      // Change
      drop_coin(2'd2);
      drop_coin(2'd2);
      chk("chg_credit50", credit, 50);
      chk("chg_coin", coin, 1);
      vend_done = 1'b1; cyc(); vend_done = 1'b0;
      chk("chg_rvalid", refund_valid, 1);
      chk("chg_ramt", refund_amt, 15);
      for (int i = 0; i < 3; i++) begin
         cyc();
         chk("chg_hold_rvalid", refund_valid, 1);
         chk("chg_hold_ramt", refund_amt, 15);
      end
      ack_refund();
      chk("chg_ack_rvalid", refund_valid, 0);
      chk("chg_ack_credit", credit, 0);

      // Cancel
      price = 8'd100;
      drop_coin(2'd1);
      chk("can_credit10", credit, 10);
      cancel = 1'b1; cyc(); cancel = 1'b0;
      chk("can_rvalid", refund_valid, 1);
      chk("can_ramt", refund_amt, 10);
      chk("can_nocoin", coin, 0);
      ack_refund();
      cancel = 1'b1; cyc(); cancel = 1'b0;
      chk("can_idle_rvalid", refund_valid, 0);
      chk("can_idle_credit", credit, 0);

      // Overflow and HOLD reject
      price = 8'd200;
      drop_coin(2'd3);
      drop_coin(2'd2);
      drop_coin(2'd2);
      drop_coin(2'd2);
      chk("ovf_credit175", credit, 175);
      drop_coin(2'd3);
      chk("ovf_reject", coin_reject, 1);
      chk("ovf_credit_kept", credit, 175);
      cyc();
      chk("ovf_reject_pulse", coin_reject, 0);
      drop_coin(2'd2);
      chk("ovf_credit200", credit, 200);
      chk("ovf_coin", coin, 1);
      chk("ovf_limit_noreject", coin_reject, 0);
      drop_coin(2'd0);
      chk("hold_reject", coin_reject, 1);
      chk("hold_credit", credit, 200);
      chk("hold_nocoin", coin, 0);
      cancel = 1'b1; cyc(); cancel = 1'b0;
      chk("hold_cancel_ramt", refund_amt, 200);
      ack_refund();

      // Simultaneity
      price = 8'd35;
      drop_coin(2'd1);
      coin_valid = 1'b1; coin_type = 2'd2; cancel = 1'b1;
      cyc();
      coin_valid = 1'b0; cancel = 1'b0;
      chk("sim_can_reject", coin_reject, 1);
      chk("sim_can_ramt", refund_amt, 10);
      chk("sim_can_credit", credit, 10);
      ack_refund();
      drop_coin(2'd2);
      drop_coin(2'd2);
      chk("sim_hold_credit50", credit, 50);
      vend_done = 1'b1; cancel = 1'b1; cyc(); vend_done = 1'b0; cancel = 1'b0;
      chk("sim_vend_rvalid", refund_valid, 1);
      chk("sim_vend_ramt", refund_amt, 15);
      ack_refund();

      // Reset mid-REFUND
      drop_coin(2'd1);
      cancel = 1'b1; cyc(); cancel = 1'b0;
      chk("rr_rvalid_pre", refund_valid, 1);
      resetn = 1'b0; cyc(); resetn = 1'b1;
      chk("rr_rvalid", refund_valid, 0);
      chk("rr_ramt", refund_amt, 0);
      chk("rr_credit", credit, 0);
      chk("rr_coin", coin, 0);
      drop_coin(2'd2);
      chk("rr_next_credit", credit, 25);
      chk("rr_next_noreject", coin_reject, 0);

      // Price drop in ACCUM, then latched price used at vend
      price = 8'd20;
      cyc();
      chk("pd_coin", coin, 1);
      cyc();
      chk("pd_coin_once", coin, 0);
      price = 8'd100;
      vend_done = 1'b1; cyc(); vend_done = 1'b0;
      chk("pd_ramt", refund_amt, 5);
      chk("pd_credit", credit, 5);
      ack_refund();
      chk("pd_ack_credit", credit, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
